// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, 8-set instruction cache controller with 32-byte lines.
// Define ICACHE_PERF_EN to add the hit_count/miss_count performance counter outputs.
`timescale 1ns/1ps
module icache_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  da_write_en,
  output logic [2:0]   da_rindex,
  output logic [2:0]   da_windex,
  output logic [255:0] da_datain,
  input  logic [255:0] da_dataout
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [26:0] line_q, line_d;
  logic [23:0] tag_q [8];
  logic [23:0] tag_d [8];
  logic [7:0]  valid_q, valid_d;
  logic        refill_q, refill_d;
  logic        hit_s, miss_s;
  logic        lookup_hit_s, same_line_s;
  logic [2:0]  req_index_s, fill_index_s;
  logic        unused_s;

  function automatic logic [31:0] select_word(input logic [255:0] line, input logic [2:0] word);
    return line[{word, 5'b00000} +: 32];
  endfunction

  assign req_index_s  = mem_address[7:5];
  assign fill_index_s = line_q[2:0];
  assign da_rindex    = req_index_s;
  assign lookup_hit_s = valid_q[req_index_s] && (tag_q[req_index_s] == mem_address[31:8]);
  // The serve right after a fill is the tail of a miss, not a new hit.
  assign same_line_s  = refill_q && (mem_address[31:5] == line_q);

  // State, latched line address, tag/valid arrays
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    line_q   <= line_d;
    tag_q    <= tag_d;
    valid_q  <= valid_d;
    refill_q <= refill_d;
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    refill_d     = 1'b0;
    hit_s        = 1'b0;
    miss_s       = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = 32'd0;
    pmem_read    = 1'b0;
    pmem_address = 32'd0;
    da_write_en  = 32'd0;
    da_windex    = 3'd0;
    da_datain    = 256'd0;
    if (rst) begin
      state_d = ST_IDLE;
      line_d  = 27'd0;
      valid_d = 8'd0;
      tag_d   = '{default: 24'd0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_read) begin
            if (lookup_hit_s) begin
              mem_resp  = 1'b1;
              mem_rdata = select_word(da_dataout, mem_address[4:2]);
              hit_s     = !same_line_s;
            end else begin
              miss_s  = 1'b1;
              line_d  = mem_address[31:5];
              state_d = ST_FETCH;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          pmem_read    = 1'b1;
          pmem_address = {line_q, 5'b00000};
          if (pmem_resp) begin
            da_write_en           = 32'hFFFF_FFFF;
            da_windex             = fill_index_s;
            da_datain             = pmem_rdata;
            tag_d[fill_index_s]   = line_q[26:3];
            valid_d[fill_index_s] = 1'b1;
            refill_d              = 1'b1;
            state_d               = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Wrapping hit/miss event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_q + {31'd0, hit_s};
      miss_count_q <= miss_count_q + {31'd0, miss_s};
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign unused_s   = ^mem_address[1:0];
`else
  assign unused_s   = ^{mem_address[1:0], hit_s, miss_s};
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: TB-side data array and line memory, random fetch
// traffic checked against a set->tag reference model.
`timescale 1ns/1ps
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  da_write_en;
  logic [2:0]   da_rindex;
  logic [2:0]   da_windex;
  logic [255:0] da_datain;
  logic [255:0] da_dataout;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .da_write_en(da_write_en), .da_rindex(da_rindex), .da_windex(da_windex),
    .da_datain(da_datain), .da_dataout(da_dataout)
`ifdef ICACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_lat = 3;
  logic [31:0] tb_fill_addr = 32'd0;
  logic        expect_fill = 1'b1;
  logic        resp_busy = 1'b0;
  logic [7:0]  ref_valid;
  logic [23:0] ref_tag [8];
  int          ref_hits = 0;
  int          ref_misses = 0;
  logic [255:0] da_mem [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory content: every word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({a[31:5], 3'(w), 2'b00});
    return l;
  endfunction

  // Data array outside the DUT, with same-cycle write bypass
  always @(posedge clk) begin
    for (int b = 0; b < 32; b++)
      if (da_write_en[b]) da_mem[da_windex][8*b +: 8] <= da_datain[8*b +: 8];
  end

  always_comb begin
    da_dataout = da_mem[da_rindex];
    if (da_write_en == 32'hFFFF_FFFF && da_windex == da_rindex) da_dataout = da_datain;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ref_valid = 8'd0;
    for (int s = 0; s < 8; s++) ref_tag[s] = 24'd0;
    ref_hits = 0;
    ref_misses = 0;
  endtask

  // Classify a request against the model and record its effect; returns 1 on hit.
  function automatic logic model_access(input logic [31:0] a);
    logic h;
    h = ref_valid[a[7:5]] && (ref_tag[a[7:5]] == a[31:8]);
    if (h) ref_hits++;
    else ref_misses++;
    ref_valid[a[7:5]] = 1'b1;
    ref_tag[a[7:5]] = a[31:8];
    return h;
  endfunction

  // Issue one held fetch and wait for its response (called just after a rising edge).
  task automatic issue(input logic [31:0] a, input int lat);
    exp_t e;
    logic h;
    logic seen;
    h = model_access(a);
    e.data = mem_word(a);
    e.lat = h ? 0 : lat + 2;
    e.issue = cyc;
    exp_q.push_back(e);
    mem_lat = lat;
    tb_fill_addr = a;
    mem_address = a;
    mem_read = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = mem_resp;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: no mem_resp for %0h, required a response", a);
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
  endtask

  task automatic wait_resp_idle();
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(posedge clk);
      #2;
      idle = !resp_busy;
    end
    if (!idle) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fill_timeout: memory responder still busy, required idle");
    end
  endtask

  task automatic check_perf();
`ifdef ICACHE_PERF_EN
    check("hit_count", 256'(hit_count), 256'(ref_hits));
    check("miss_count", 256'(miss_count), 256'(ref_misses));
`endif
  endtask

  // Monitor: every mem_resp pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: mem_resp=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          check("mem_rdata", 256'(mem_rdata), 256'(e.data));
          check("latency", 256'(cyc - e.issue), 256'(e.lat));
        end
      end
    end
  end

  // Line memory: answers pmem_read after mem_lat cycles and checks the fill cycle
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = 256'd0;
    forever begin
      @(negedge clk);
      if (pmem_read) begin
        resp_busy = 1'b1;
        check("pmem_address", 256'(pmem_address), 256'({tb_fill_addr[31:5], 5'b00000}));
        repeat (mem_lat) @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        pmem_rdata = line_of(tb_fill_addr);
        @(negedge clk);
        if (expect_fill) begin
          check("fill_write_en", 256'(da_write_en), 256'(32'hFFFF_FFFF));
          check("fill_windex", 256'(da_windex), 256'(tb_fill_addr[7:5]));
          check("fill_datain", da_datain, line_of(tb_fill_addr));
          check("fill_pmem_address", 256'(pmem_address), 256'({tb_fill_addr[31:5], 5'b00000}));
        end else begin
          check("idle_resp_write_en", 256'(da_write_en), 256'd0);
        end
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        pmem_rdata = 256'd0;
        @(negedge clk);
        check("pmem_read_drop", 256'(pmem_read), 256'd0);
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int s = 0; s < 8; s++) da_mem[s] = 256'd0;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_address = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_resp", 256'(mem_resp), 256'd0);
    check("rst_pmem_read", 256'(pmem_read), 256'd0);
    check("rst_write_en", 256'(da_write_en), 256'd0);
    check("rst_mem_rdata", 256'(mem_rdata), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_perf();

    // Cold miss, hit in the same line, conflict replacement, re-miss
    issue(32'h0000_0044, 3);
    issue(32'h0000_0048, 3);
    issue(32'h0000_0140, 2);
    issue(32'h0000_0040, 4);
    check_perf();

    // Fill completes with the latched address even after the request is withdrawn
    tb_fill_addr = 32'h0000_0080;
    mem_lat = 3;
    void'(model_access(32'h0000_0080));
    mem_address = 32'h0000_0080;
    mem_read = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_address = 32'h0000_00A0;
    mem_read = 1'b0;
    wait_resp_idle();
    issue(32'h0000_0084, 2);
    issue(32'h0000_00A0, 1);

    // Random traffic over a small tag space so hits and conflicts both occur
    for (int i = 0; i < 150; i++) begin
      a = {24'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      issue(a, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    check_perf();

    // Reset in the middle of a fill abandons it; the late pmem_resp lands in IDLE
    expect_fill = 1'b0;
    tb_fill_addr = 32'h0000_0300;
    mem_lat = 8;
    mem_address = 32'h0000_0300;
    mem_read = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_pmem_read", 256'(pmem_read), 256'd0);
    wait_resp_idle();
    expect_fill = 1'b1;
    issue(32'h0000_0300, 2);
    check_perf();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: mem_address  input  32  CPU fetch address; tag=[31:8], index=[7:5], word=[4:2].
REQ-004 SHALL have port: mem_read  input  1  CPU fetch request, held until mem_resp.
REQ-005 SHALL have port: mem_rdata  output  32  fetched instruction word.
REQ-006 SHALL have port: mem_resp  output  1  one-cycle fetch-complete pulse.
REQ-007 SHALL have port: pmem_address  output  32  line address to memory, low 5 bits zero.
REQ-008 SHALL have port: pmem_read  output  1  line read request, held until pmem_resp.
REQ-009 SHALL have port: pmem_rdata  input  256  returned cache line.
REQ-010 SHALL have port: pmem_resp  input  1  line-valid strobe.
REQ-011 SHALL have port: da_write_en  output  32  data-array byte write mask.
REQ-012 SHALL have port: da_rindex / da_windex  output  3 each  data-array read/write set.
REQ-013 SHALL have port: da_datain  output  256  data-array write line; da_dataout  input  256  data-array read line (combinational, write-bypassed).

Function
REQ-014 SHALL hold per set (8 sets, direct-mapped) a 24-bit tag register and a valid bit.
REQ-015 SHALL implement FSM states IDLE and FETCH; reset state IDLE.
REQ-016 SHALL drive da_rindex = mem_address[7:5] combinationally in every state.
REQ-017 SHALL, in IDLE with mem_read=1 and valid[index]=1 and tag match (hit), assert mem_resp in that same cycle, mem_rdata = da_dataout[32*word +: 32]; remain IDLE.
REQ-018 SHALL, in IDLE with mem_read=1 and miss, latch mem_address and enter FETCH next cycle; mem_resp=0.
REQ-019 SHALL, in FETCH, assert pmem_read=1 with pmem_address = {latched[31:5], 5'b0}, stable until pmem_resp.
REQ-020 SHALL, in the FETCH cycle with pmem_resp=1: da_write_en=32'hFFFF_FFFF, da_windex=latched index, da_datain=pmem_rdata, update tag, set valid, return to IDLE; pmem_read deasserts next cycle.
REQ-021 SHALL, outside REQ-020's cycle, hold da_write_en=0, da_datain=0, da_windex=0.
REQ-022 SHALL complete an issued fill even if mem_read drops or mem_address changes during FETCH (latched address used).
REQ-023 SHALL give miss latency = memory latency + 1 cycle (hit served in IDLE after fill); hit latency 0 cycles.
REQ-024 SHALL treat a fill to an occupied set as replacement (old tag overwritten, no writeback).
REQ-025 SHALL ignore pmem_resp in IDLE.

Reset
REQ-026 SHALL on rst: state=IDLE, all valid=0, tags=0, mem_resp=0, pmem_read=0, da_write_en=0, mem_rdata=0.
REQ-027 SHALL on rst during FETCH abandon the fill: no array write, no tag/valid update, pmem_read=0 next cycle.

Configuration
REQ-028 SHALL, with ICACHE_PERF_EN defined, add outputs hit_count and miss_count (32 bits each), incremented on each REQ-017 hit / REQ-018 miss, wrapping at 2^32, cleared by rst.
REQ-029 SHALL, without ICACHE_PERF_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-030 Cold read: rst, then mem_read addr 0x0000_0044 -> pmem_read with pmem_address 0x0000_0040; pmem_resp after 3 cycles -> write_en=FFFF_FFFF, windex=2; next cycle mem_resp with word 1.
REQ-031 Hit: repeat 0x0000_0048 -> mem_resp same cycle, pmem_read=0, word 2 of line.
REQ-032 Conflict: read 0x0000_0140 (index 2, new tag) -> miss, refill; then 0x0000_0040 -> miss again.
REQ-033 Address change: during FETCH for 0x0000_0080 switch mem_address to 0x0000_00A0 -> pmem_address stays 0x0000_0080, fill to set 4.
REQ-034 Reset mid-FETCH: rst asserted before pmem_resp -> pmem_read=0, subsequent read to same address misses.
REQ-035 ICACHE_PERF_EN: sequence of REQ-030..032 -> hit_count=1, miss_count=3 at end.
